piso_tx_sched: RTL and testbench

- Round-robin scheduler that shares one 32-bit PISO serializer between N_SRC word sources.
- Accepts one word per frame from a source through a valid/ready handshake. It then sequences the serializer: a one-cycle load pulse, a fixed-length xmit window, then an idle gap.
- Sits between the readout/status word producers and the serializer that drives the serial data/clock pins.

---
 rtl/piso_tx_sched_pkg.sv | 19 +
 rtl/piso_tx_sched_rr_arbiter.sv | 36 +++
 rtl/piso_tx_sched.sv | 129 ++++++++++++
 tb/tb_piso_tx_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_tx_sched_pkg.sv
// Shared types and default constants for the PISO transmit scheduler and its serializer.
package piso_tx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        GAP
    } state_t;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_SHIFT_CYCLES = 64;

    // Index width able to address n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first valid source scanning upward from ptr+1, modulo N_SRC.
module piso_tx_sched_rr_arbiter
    import piso_tx_sched_pkg::*;
#(
    parameter int N_SRC = 4,
    localparam int ID_W = idx_width(N_SRC)
) (
    input  logic [N_SRC-1:0] valid,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  sel,
    output logic             any_valid
);

    logic [N_SRC-1:0] rot;
    logic [ID_W-1:0]  slot_idx [N_SRC];

    // Slot gi holds the source that is gi+1 positions past the pointer.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rot
            assign slot_idx[gi] = ID_W'((int'(ptr) + 1 + gi) % N_SRC);
            assign rot[gi]      = valid[slot_idx[gi]];
        end
    endgenerate

    always_comb begin
        sel       = ptr;
        any_valid = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sel       = slot_idx[k];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler feeding one shared PISO serializer: accept, load pulse, xmit window, idle gap.
module piso_tx_sched
    import piso_tx_sched_pkg::*;
#(
    parameter int N_SRC        = 4,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int SHIFT_CYCLES = DEF_SHIFT_CYCLES,
    parameter int GAP_CYCLES   = 4,
    parameter int CNT_W        = 16,
    localparam int ID_W        = idx_width(N_SRC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_SRC-1:0]        src_valid,
    input  logic [N_SRC*DATA_W-1:0] src_data,
    output logic [N_SRC-1:0]        src_ready,
    output logic                    piso_load,
    output logic                    piso_xmit,
    output logic [DATA_W-1:0]       piso_data,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id,
    output logic [CNT_W-1:0]        words_sent
);

    localparam int CYC_MAX = (SHIFT_CYCLES > GAP_CYCLES) ? SHIFT_CYCLES : GAP_CYCLES;
    localparam int CYC_W   = idx_width(CYC_MAX);

    state_t              state_reg, state_next;
    logic [CYC_W-1:0]    cyc_reg, cyc_next;
    logic [N_SRC-1:0]    src_ready_reg, src_ready_next;
    logic                piso_load_reg, piso_load_next;
    logic                piso_xmit_reg, piso_xmit_next;
    logic [DATA_W-1:0]   piso_data_reg, piso_data_next;
    logic                busy_reg;
    logic [ID_W-1:0]     grant_id_reg, grant_id_next;
    logic [CNT_W-1:0]    words_sent_reg, words_sent_next;

    logic [ID_W-1:0]     arb_sel;
    logic                arb_any;

    piso_tx_sched_rr_arbiter #(
        .N_SRC (N_SRC)
    ) u_arb (
        .valid     (src_valid),
        .ptr       (grant_id_reg),
        .sel       (arb_sel),
        .any_valid (arb_any)
    );

    // Outputs are registered copies of what the current state asks for, so each
    // strobe appears one cycle after the state that requests it.
    always_comb begin
        state_next      = state_reg;
        cyc_next        = cyc_reg;
        src_ready_next  = '0;
        piso_load_next  = 1'b0;
        piso_xmit_next  = 1'b0;
        piso_data_next  = piso_data_reg;
        grant_id_next   = grant_id_reg;
        words_sent_next = words_sent_reg;
        case (state_reg)
            IDLE: begin
                if (enable && arb_any) begin
                    src_ready_next[arb_sel] = 1'b1;
                    piso_data_next          = src_data[int'(arb_sel)*DATA_W +: DATA_W];
                    grant_id_next           = arb_sel;
                    state_next              = LOAD;
                end
            end
            LOAD: begin
                piso_load_next = 1'b1;
                cyc_next       = '0;
                state_next     = SHIFT;
            end
            SHIFT: begin
                piso_xmit_next = 1'b1;
                if (cyc_reg == CYC_W'(SHIFT_CYCLES - 1)) begin
                    cyc_next        = '0;
                    words_sent_next = words_sent_reg + CNT_W'(1);
                    state_next      = GAP;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            GAP: begin
                if (cyc_reg == CYC_W'(GAP_CYCLES - 1)) begin
                    state_next = IDLE;
                end else begin
                    cyc_next = cyc_reg + CYC_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cyc_reg        <= '0;
            src_ready_reg  <= '0;
            piso_load_reg  <= 1'b0;
            piso_xmit_reg  <= 1'b0;
            piso_data_reg  <= '0;
            busy_reg       <= 1'b0;
            grant_id_reg   <= ID_W'(N_SRC - 1);
            words_sent_reg <= '0;
        end else begin
            state_reg      <= state_next;
            cyc_reg        <= cyc_next;
            src_ready_reg  <= src_ready_next;
            piso_load_reg  <= piso_load_next;
            piso_xmit_reg  <= piso_xmit_next;
            piso_data_reg  <= piso_data_next;
            busy_reg       <= (state_next != IDLE);
            grant_id_reg   <= grant_id_next;
            words_sent_reg <= words_sent_next;
        end
    end

    assign src_ready  = src_ready_reg;
    assign piso_load  = piso_load_reg;
    assign piso_xmit  = piso_xmit_reg;
    assign piso_data  = piso_data_reg;
    assign busy       = busy_reg;
    assign grant_id   = grant_id_reg;
    assign words_sent = words_sent_reg;

endmodule

// File: tb/tb_piso_tx_sched.sv
// Self-checking bench for piso_tx_sched: frame-timeline reference model, vector table, corner sequences.
module tb_piso_tx_sched;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int SC    = 64;
    localparam int GC    = 4;
    localparam int FRAME = 2 + SC + GC;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [N-1:0]      src_valid;
    logic [N*DW-1:0]   src_data;
    logic [N-1:0]      src_ready;
    logic              piso_load;
    logic              piso_xmit;
    logic [DW-1:0]     piso_data;
    logic              busy;
    logic [1:0]        grant_id;
    logic [15:0]       words_sent;

    logic [N-1:0]      w_src_ready;
    logic              w_piso_load;
    logic              w_piso_xmit;
    logic [DW-1:0]     w_piso_data;
    logic              w_busy;
    logic [1:0]        w_grant_id;
    logic [1:0]        w_words_sent;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;

    // Reference model: frame position relative to the accept cycle (-1 = no frame).
    int          m_t    = -1;
    int          m_cnt  = 0;
    int          m_last = N - 1;
    logic [DW-1:0] m_data = '0;

    piso_tx_sched #(
        .N_SRC(N), .DATA_W(DW), .SHIFT_CYCLES(SC), .GAP_CYCLES(GC), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .src_valid(src_valid), .src_data(src_data),
        .src_ready(src_ready), .piso_load(piso_load), .piso_xmit(piso_xmit),
        .piso_data(piso_data), .busy(busy), .grant_id(grant_id), .words_sent(words_sent)
    );

    piso_tx_sched #(
        .N_SRC(N), .DATA_W(DW), .SHIFT_CYCLES(SC), .GAP_CYCLES(GC), .CNT_W(2)
    ) dut_wrap (
        .clk(clk), .rst(rst), .enable(enable), .src_valid(src_valid), .src_data(src_data),
        .src_ready(w_src_ready), .piso_load(w_piso_load), .piso_xmit(w_piso_xmit),
        .piso_data(w_piso_data), .busy(w_busy), .grant_id(w_grant_id), .words_sent(w_words_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output logic [N-1:0] r);
        r = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (src_ready != '0) begin
                r = src_ready;
                break;
            end
        end
    endtask

    task automatic model_step();
        if (rst) begin
            m_t = -1; m_cnt = 0; m_last = N - 1; m_data = '0;
        end else if (m_t == -1 || m_t == FRAME - 1) begin
            m_t = -1;
            if (enable && src_valid != '0) begin
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_last + k) % N;
                    if (src_valid[idx]) begin
                        m_last = idx;
                        m_data = src_data[idx*DW +: DW];
                        m_t    = 0;
                        break;
                    end
                end
            end
        end else begin
            m_t++;
            if (m_t == SC + 1) m_cnt++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Per-cycle comparison of every output against the frame timeline.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                chk("src_ready", 64'(src_ready), 64'((m_t == 0) ? (4'b0001 << m_last) : 4'b0000));
                chk("piso_load", 64'(piso_load), 64'(m_t == 1));
                chk("piso_xmit", 64'(piso_xmit), 64'(m_t >= 2 && m_t <= SC + 1));
                chk("piso_data", 64'(piso_data), 64'(m_data));
                chk("busy", 64'(busy), 64'(m_t >= 0 && m_t <= FRAME - 2));
                chk("grant_id", 64'(grant_id), 64'(m_last));
                chk("words_sent", 64'(words_sent), 64'(m_cnt % 65536));
                chk("wrap_words_sent", 64'(w_words_sent), 64'(m_cnt % 4));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [N-1:0] valid;
        int           exp_grant;
        int           exp_gap;
    } vec_t;

    vec_t         tbl [10];
    logic [N-1:0] r;
    int           last_cyc;
    int           xc;
    int           lc;
    int           rc;

    initial begin
        tbl[0] = '{4'b1111, 1, 0};
        tbl[1] = '{4'b1111, 2, FRAME};
        tbl[2] = '{4'b1111, 3, FRAME};
        tbl[3] = '{4'b1111, 0, FRAME};
        tbl[4] = '{4'b0100, 2, FRAME};
        tbl[5] = '{4'b0100, 2, FRAME};
        tbl[6] = '{4'b1001, 3, FRAME};
        tbl[7] = '{4'b1001, 0, FRAME};
        tbl[8] = '{4'b0110, 1, FRAME};
        tbl[9] = '{4'b0110, 2, FRAME};

        rst = 1'b1; enable = 1'b0; src_valid = '0; src_data = '0;
        step();
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_grant_id", 64'(grant_id), 64'(N - 1));
        chk("reset_busy", 64'(busy), 64'(0));
        step();
        rst = 1'b0;

        // Single word from source 0
        enable = 1'b1;
        src_valid = 4'b0001;
        src_data[0 +: DW] = 32'hA5A5_0F0F;
        for (int i = 1; i < N; i++) src_data[i*DW +: DW] = 32'h1111_0000 * i;
        wait_ready(r);
        chk("single_ready", 64'(r), 64'(4'b0001));
        chk("single_data", 64'(piso_data), 64'(32'hA5A5_0F0F));
        step();
        src_valid = '0;
        xc = 0; lc = 0;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (piso_xmit) xc++;
            if (piso_load) lc++;
        end
        chk("single_xmit_len", 64'(xc), 64'(SC));
        chk("single_load_len", 64'(lc), 64'(1));
        chk("single_words", 64'(words_sent), 64'(1));
        chk("single_hold", 64'(piso_data), 64'(32'hA5A5_0F0F));

        // Round-robin table
        for (int i = 0; i < N; i++) src_data[i*DW +: DW] = 32'hC0DE_0000 + i;
        last_cyc = 0;
        for (int v = 0; v < 10; v++) begin
            step();
            src_valid = tbl[v].valid;
            wait_ready(r);
            chk("rr_ready", 64'(r), 64'(4'b0001 << tbl[v].exp_grant));
            chk("rr_grant", 64'(grant_id), 64'(tbl[v].exp_grant));
            if (tbl[v].exp_gap != 0) chk("rr_period", 64'(cyc - last_cyc), 64'(tbl[v].exp_gap));
            last_cyc = cyc;
        end
        step();
        src_valid = '0;
        repeat (FRAME + 2) @(negedge clk);

        // Enable dropped mid-xmit
        step();
        src_valid = 4'b0001;
        wait_ready(r);
        chk("en_ready", 64'(r), 64'(4'b0001));
        xc = 0; rc = 0;
        for (int i = 0; i < 100 && xc < 10; i++) begin
            @(negedge clk);
            if (piso_xmit) xc++;
        end
        step();
        enable = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (piso_xmit) xc++;
            if (src_ready != '0) rc++;
        end
        chk("en_xmit_len", 64'(xc), 64'(SC));
        chk("en_no_grant", 64'(rc), 64'(0));
        step();
        enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("en_resume", 64'(src_ready), 64'(4'b0001));

        // Reset mid-frame
        xc = 0;
        for (int i = 0; i < 100 && xc < 30; i++) begin
            @(negedge clk);
            if (piso_xmit) xc++;
        end
        step();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_xmit", 64'(piso_xmit), 64'(0));
        chk("rst_words", 64'(words_sent), 64'(0));
        chk("rst_grant", 64'(grant_id), 64'(3));
        step();
        rst = 1'b0;
        src_valid = 4'b0101;
        wait_ready(r);
        chk("rst_next_src0", 64'(r), 64'(4'b0001));

        // Withdrawn request
        step();
        src_valid = 4'b0010;
        wait_ready(r);
        chk("wd_src1", 64'(r), 64'(4'b0010));
        step();
        src_valid = 4'b0110;
        repeat (20) step();
        src_valid = 4'b1000;
        wait_ready(r);
        chk("wd_src3", 64'(r), 64'(4'b1000));
        chk("wd_grant3", 64'(grant_id), 64'(3));
        step();
        src_valid = '0;
        repeat (FRAME + 2) step();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step();
            src_valid = N'($urandom);
            enable    = ($urandom_range(0, 7) != 0);
            rst       = ($urandom_range(0, 599) == 0);
            for (int s = 0; s < N; s++) src_data[s*DW +: DW] = $urandom;
        end
        step();
        rst = 1'b0;
        src_valid = '0;
        repeat (FRAME + 2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
